// File: rtl/result_stream_drain_pkg.sv
// result_stream_drain_pkg: shared element/matrix types and index sizing for the systolic datapath
package result_stream_drain_pkg;
  localparam int ELEM_W_DEF = 32;
  localparam int N_DEF = 4;
  typedef logic [ELEM_W_DEF-1:0] elem_t;
  typedef elem_t [N_DEF-1:0][N_DEF-1:0] mat_t;
  typedef enum logic {IDLE, STREAM} drain_state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/result_stream_drain_index_counter.sv
// stream_index_counter: row-major row/col walker with advance enable, last flag and sync clear
module stream_index_counter
  import result_stream_drain_pkg::*;
#(
  parameter int N = N_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [IW-1:0] o_row,
  output logic [IW-1:0] o_col,
  output logic          o_last
);
  logic [IW-1:0] r_row, r_col;
  logic w_col_end, w_row_end;
  // explicit N-1 compares: N need not be a power of two
  assign w_col_end = (r_col == IW'(N-1));
  assign w_row_end = (r_row == IW'(N-1));
  assign o_row = r_row;
  assign o_col = r_col;
  assign o_last = w_row_end & w_col_end;
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      r_col <= w_col_end ? '0 : r_col + 1'b1;
      if (w_col_end) r_row <= w_row_end ? '0 : r_row + 1'b1;
    end
endmodule

// File: rtl/result_stream_drain.sv
// result_stream_drain: ping-pong capture of result matrices, drained as a row-major valid/ready stream
module result_stream_drain
  import result_stream_drain_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic                             i_clk,
  input  logic                             i_arst_n,
  input  logic [N-1:0][N-1:0][ELEM_W-1:0]  i_c,
  input  logic                             i_validResult,
  output logic                             o_canAccept,
  output logic [ELEM_W-1:0]                o_data,
  output logic [IW-1:0]                    o_row,
  output logic [IW-1:0]                    o_col,
  output logic                             o_last,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_overflow,
  input  logic                             i_clearOverflow
);
  if (N <= 2 || N >= 256) begin : g_bad_n
    $error("result_stream_drain: N must satisfy 2 < N < 256");
  end
  logic [N-1:0][N-1:0][ELEM_W-1:0] r_slot [2];
  logic [1:0] r_full, w_full_free, w_full_nxt;
  logic r_wr_ptr, r_rd_ptr, r_overflow;
  drain_state_t r_state, w_state_nxt;
  logic w_hs, w_last, w_last_hs, w_cap, w_drop;
  logic [IW-1:0] w_row, w_col;
  assign o_valid = (r_state == STREAM);
  assign w_hs = o_valid & i_ready;
  assign w_last_hs = w_hs & w_last;
  // a slot freed by the final handshake is reusable by a pulse in the same cycle
  assign w_full_free = r_full & ~({r_rd_ptr, ~r_rd_ptr} & {2{w_last_hs}});
  assign w_cap = i_validResult & ~w_full_free[r_wr_ptr];
  assign w_drop = i_validResult & w_full_free[r_wr_ptr];
  assign w_full_nxt = w_full_free | ({r_wr_ptr, ~r_wr_ptr} & {2{w_cap}});
  assign o_canAccept = ~&r_full;
  assign o_data = o_valid ? r_slot[r_rd_ptr][w_row][w_col] : '0;
  assign o_row = w_row;
  assign o_col = w_col;
  assign o_last = o_valid & w_last;
  assign o_overflow = r_overflow;
  stream_index_counter #(.N(N)) u_idx (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_clr    (w_last_hs),
    .i_adv    (w_hs),
    .o_row    (w_row),
    .o_col    (w_col),
    .o_last   (w_last)
  );
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) w_state_nxt = w_full_nxt[r_rd_ptr] ? STREAM : IDLE;
    else if (w_last_hs) w_state_nxt = w_full_nxt[~r_rd_ptr] ? STREAM : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_arst_n)
    if (!i_arst_n) begin
      r_state <= IDLE;
      r_full <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full <= w_full_nxt;
      r_wr_ptr <= r_wr_ptr ^ w_cap;
      r_rd_ptr <= r_rd_ptr ^ w_last_hs;
      r_overflow <= w_drop | (r_overflow & ~i_clearOverflow);
    end
  always_ff @(posedge i_clk)
    if (w_cap) r_slot[r_wr_ptr] <= i_c;
endmodule

// File: tb/tb_result_stream_drain.sv
// tb_result_stream_drain: randomized directed steps checked against a matrix-queue model
module tb_result_stream_drain;
  import result_stream_drain_pkg::*;
  localparam int N = N_DEF;
  localparam int IW = idx_w(N);
  logic i_clk = 1'b0, i_arst_n = 1'b0;
  mat_t i_c = '0;
  logic i_validResult = 1'b0, i_ready = 1'b0, i_clearOverflow = 1'b0;
  logic o_canAccept, o_last, o_valid, o_overflow;
  logic [31:0] o_data;
  logic [IW-1:0] o_row, o_col;
  typedef struct {logic [31:0] d; int r; int c; bit l;} beat_t;
  beat_t q[$];
  int cnt = 0, beats = 0, checks = 0, errors = 0;
  bit ovf = 1'b0;
  mat_t nm;
  result_stream_drain #(.N(N), .ELEM_W(32)) dut (
    .i_clk(i_clk), .i_arst_n(i_arst_n), .i_c(i_c), .i_validResult(i_validResult),
    .o_canAccept(o_canAccept), .o_data(o_data), .o_row(o_row), .o_col(o_col),
    .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready), .o_overflow(o_overflow),
    .i_clearOverflow(i_clearOverflow)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rand_mat();
    for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) nm[r][k] = $urandom;
  endtask
  // one clock: drive, compare against the model, advance the model across the edge
  task automatic cyc(input bit vr, input bit rdy, input bit clr);
    beat_t b;
    bit drop;
    i_validResult = vr;
    i_ready = rdy;
    i_clearOverflow = clr;
    if (vr) i_c = nm;
    else for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) i_c[r][k] = $urandom;
    #1;
    chk("valid", o_valid, cnt > 0);
    chk("can_accept", o_canAccept, cnt < 2);
    chk("overflow", o_overflow, ovf);
    if (cnt > 0) begin
      chk("data", o_data, q[0].d);
      chk("row", o_row, q[0].r);
      chk("col", o_col, q[0].c);
      chk("last", o_last, q[0].l);
    end
    if (cnt > 0 && rdy) begin
      b = q.pop_front();
      beats++;
      if (b.l) cnt--;
    end
    drop = vr && cnt == 2;
    if (vr && !drop) begin
      for (int r = 0; r < N; r++)
        for (int k = 0; k < N; k++) q.push_back('{nm[r][k], r, k, (r == N-1 && k == N-1)});
      cnt++;
    end
    if (drop) ovf = 1'b1;
    else if (clr) ovf = 1'b0;
    @(posedge i_clk);
    #1;
  endtask
  task automatic do_reset();
    i_arst_n = 1'b0;
    i_validResult = 1'b0;
    i_ready = 1'b0;
    i_clearOverflow = 1'b0;
    #2;
    q.delete();
    cnt = 0;
    ovf = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_last", o_last, 0);
    chk("rst_data", o_data, 0);
    chk("rst_row", o_row, 0);
    chk("rst_col", o_col, 0);
    chk("rst_can_accept", o_canAccept, 1);
    chk("rst_overflow", o_overflow, 0);
    @(negedge i_clk);
    i_arst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    bit done, p;
    @(posedge i_clk);
    #1;
    do_reset();
    for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) nm[r][k] = 32'(16*r + k);
    cyc(1, 1, 0);
    repeat (20) cyc(0, 1, 0);
    rand_mat();
    cyc(1, 1, 0);
    for (int i = 0; i < 70; i++) cyc(0, (i % 4 == 0) || (i % 4 == 3), 0);
    rand_mat();
    cyc(1, 1, 0);
    repeat (2) cyc(0, 1, 0);
    rand_mat();
    cyc(1, 1, 0);
    repeat (40) cyc(0, 1, 0);
    rand_mat();
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    rand_mat();
    cyc(1, 0, 0);
    rand_mat();
    cyc(1, 0, 0);
    rand_mat();
    cyc(1, 0, 1);
    cyc(0, 0, 1);
    repeat (40) cyc(0, 1, 0);
    rand_mat();
    cyc(1, 0, 0);
    rand_mat();
    cyc(1, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      p = (cnt == 2) && q[0].l && !done;
      if (p) begin
        rand_mat();
        done = 1'b1;
      end
      cyc(p, 1, 0);
    end
    rand_mat();
    cyc(1, 1, 0);
    beats = 0;
    for (int i = 0; i < 20 && beats < 7; i++) cyc(0, 1, 0);
    do_reset();
    rand_mat();
    cyc(1, 1, 0);
    repeat (20) cyc(0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      p = ($urandom_range(0, 5) == 0);
      if (p) rand_mat();
      cyc(p, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (40) cyc(0, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
